wb_master_bridge: RTL and testbench
===================================

Name: wb_master_bridge

Overview:
- Parametrised Wishbone B4 classic master bridge between the RV64I core load/store path and the shared Wishbone interconnect.
- Converts a single core request into a proper CYC/STB/ACK bus cycle.
- Generates byte selects from access size and address, aligns data onto byte lanes, and sign/zero-extends read data.
- Stalls the core for the bus cycle duration and reports error and timeout conditions.

Parameters:
ADDR_WIDTH, 64, address width (core and bus).
DATA_WIDTH, 64, data bus width; legal values 32 or 64. Select width SEL_W = DATA_WIDTH/8.
TIMEOUT_CYC, 255, maximum cycles STB may wait for ACK/ERR before abort; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_i  in  1  core access request; held until done_o
wr_i  in  1  1 = store, 0 = load
size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = double
unsigned_i  in  1  load zero-extend (1) or sign-extend (0)
addr_i  in  ADDR_WIDTH  byte address
dat_from_core_i  in  DATA_WIDTH  store data, LSB-justified
dat_to_core_o  out  DATA_WIDTH  extended load data
busy_o  out  1  core stall; high from req acceptance until done
done_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle error pulse, coincident with done_o
wb_m_addr_o  out  ADDR_WIDTH  bus address, lane offset bits forced to 0
wb_m_dat_i  in  DATA_WIDTH  bus read data
wb_m_dat_o  out  DATA_WIDTH  lane-shifted write data
wb_m_we_o  out  1  write enable
wb_m_sel_o  out  SEL_W  byte lane selects
wb_m_stb_o  out  1  strobe
wb_m_cyc_o  out  1  cycle
wb_m_ack_i  in  1  normal termination
wb_m_err_i  in  1  error termination

Behaviour:
- Reset: all outputs 0. dat_to_core_o = 0. FSM = IDLE. Timeout counter = 0.
- Reset mid-cycle: CYC/STB drop asynchronously. The pending transaction is lost; no done_o is produced.
- FSM states and transitions:
  - IDLE: on req_i, check legality. Misaligned access (addr not a multiple of access size), or size 3 with DATA_WIDTH = 32, goes to RESP with error. No bus cycle is issued.
  - IDLE, legal request: latch addr, we, sel and shifted data; go to BUS.
  - BUS: CYC = STB = 1; bus outputs come from registers and are stable throughout.
  - BUS, wb_m_err_i: go to RESP with error.
  - BUS, wb_m_ack_i: capture read data; go to RESP.
  - BUS, counter == TIMEOUT_CYC (when nonzero): go to RESP with error.
  - RESP: done_o = 1 for one cycle, err_o as flagged; return to IDLE.
- Latency: req sampled at edge N; CYC/STB high from N+1. ACK sampled at edge M; CYC/STB low and done_o high in cycle M+1. Zero-wait-state slave: 3 cycles request to done.
- busy_o = (state != IDLE) or req_i. This is combinational so the core stalls in the request cycle.
- Simultaneous ack and err: err wins.
- ack/err received outside BUS: ignored.
- req_i in RESP: ignored. A new request is accepted only in IDLE, so back-to-back accesses have one IDLE cycle between them.
- Lane offset = addr[log2(SEL_W)-1:0].
- sel = ((1 << (1 << size)) - 1) << offset.
- wb_m_dat_o = dat_from_core_i << (8*offset).
- Loads: shift right by 8*offset, mask to the access size, extend per unsigned_i.
- dat_to_core_o updates only on a successful load and holds otherwise. On error it is 0.
- Timeout counter: clears on entry to BUS, increments each BUS cycle, saturates.

Decomposition:
- as_pack gains:
  - size encoding typedef (SZ_B, SZ_H, SZ_W, SZ_D)
  - FSM state enum (IDLE, BUS, RESP)
  - wbdSel, which must equal DATA_WIDTH/8
- One natural sub-module: wb_lane_align. It is combinational and handles sel generation, write shift, read shift and extension, and misalignment detection. It is reused by future slave bridges.

Test Plan:
- Store double, addr 0x1000, data 0x1122334455667788, ack after 2 wait states -> sel 0xFF, we 1, STB high for 3 cycles, done_o 1 cycle later, err_o 0.
- Load byte signed, addr 0x2005, bus data 0x0000_8000_0000_0000 -> sel 0x20, dat_to_core_o 0xFFFF_FFFF_FFFF_FF80. Repeat with unsigned_i = 1 -> 0x80.
- Store half to addr 0x3003 -> no CYC asserted, done_o and err_o pulse in cycle 2.
- Load word, slave never acks, TIMEOUT_CYC = 4 -> STB high exactly 4 cycles, then err_o = 1 and dat_to_core_o = 0.
- ack and err asserted together on a store -> err_o = 1. A following load with ack completes normally.
- rst_i asserted while STB is high -> CYC/STB fall with no clock edge and no done_o. Post-reset load completes normally.

Source files
------------

// File: rtl/wb_master_bridge_pkg.sv
// rtl/wb_master_bridge_pkg.sv - shared types and helpers for the Wishbone master bridge
//
// Purpose: access-size encoding, bridge FSM states and the byte-select width
// helper used by the bridge and by the lane-alignment block.
package wb_master_bridge_pkg;

  // Access size as driven by the core load/store unit
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  // Bridge FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of byte lanes on a data bus of width dw
  function automatic int wbd_sel(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// rtl/wb_lane_align.sv - byte-lane select, write/read alignment and load extension
//
// Purpose: purely combinational lane handling shared by Wishbone bridges.
// Ports:
//   i_size        access size (size_t encoding)
//   i_unsigned    1 = zero-extend loads, 0 = sign-extend
//   i_addr_lo     low three address bits
//   i_core_wdata  LSB-justified store data from the core
//   i_bus_rdata   raw bus read data
//   o_sel         byte lane selects
//   o_bus_wdata   store data shifted onto its lanes
//   o_core_rdata  load data shifted down, masked and extended
//   o_misaligned  address not a multiple of the size, or size too wide for the bus
module wb_lane_align
  import wb_master_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [1:0]              i_size,
  input  logic                    i_unsigned,
  input  logic [2:0]              i_addr_lo,
  input  logic [DATA_WIDTH-1:0]   i_core_wdata,
  input  logic [DATA_WIDTH-1:0]   i_bus_rdata,
  output logic [DATA_WIDTH/8-1:0] o_sel,
  output logic [DATA_WIDTH-1:0]   o_bus_wdata,
  output logic [DATA_WIDTH-1:0]   o_core_rdata,
  output logic                    o_misaligned
);

  localparam int SEL_W = wbd_sel(DATA_WIDTH);
  localparam int OFF_W = $clog2(SEL_W);

  logic [OFF_W-1:0]      w_off;
  logic [SEL_W-1:0]      w_mask;
  logic [DATA_WIDTH-1:0] w_rd_shift;
  logic                  w_sign;
  logic                  w_ext;
  int                    w_nbits;

  assign w_off       = i_addr_lo[OFF_W-1:0];
  assign o_sel       = w_mask << w_off;
  assign o_bus_wdata = i_core_wdata << {w_off, 3'b000};

  always_comb begin
    w_mask       = '1;
    o_misaligned = 1'b0;
    case (size_t'(i_size))
      SZ_B: begin
        w_mask       = SEL_W'(1);
        o_misaligned = 1'b0;
      end
      SZ_H: begin
        w_mask       = SEL_W'(3);
        o_misaligned = i_addr_lo[0];
      end
      SZ_W: begin
        w_mask       = SEL_W'(15);
        o_misaligned = |i_addr_lo[1:0];
      end
      default: begin
        // A double cannot travel on a 32-bit bus at all
        w_mask       = '1;
        o_misaligned = (|i_addr_lo) || (DATA_WIDTH == 32);
      end
    endcase
  end

  // Loads: bring the addressed lanes down to bit 0, then fill everything
  // above the access width with the extension bit.
  always_comb begin
    w_rd_shift   = i_bus_rdata >> {w_off, 3'b000};
    w_nbits      = 8 << i_size;
    w_sign       = 1'b0;
    o_core_rdata = '0;
    case (size_t'(i_size))
      SZ_B:    w_sign = w_rd_shift[7];
      SZ_H:    w_sign = w_rd_shift[15];
      SZ_W:    w_sign = w_rd_shift[31];
      default: w_sign = w_rd_shift[DATA_WIDTH-1];
    endcase
    w_ext = w_sign & ~i_unsigned;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      o_core_rdata[i] = (i < w_nbits) ? w_rd_shift[i] : w_ext;
    end
  end

endmodule

// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - Wishbone B4 classic master bridge for the core load/store path
//
// Purpose: turns one held core request into a single CYC/STB/ACK bus cycle,
// stalls the core meanwhile and reports completion, bus error and timeout.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_i/wr_i/size_i/unsigned_i/addr_i/dat_from_core_i   core request
//   dat_to_core_o           extended load data (held between loads)
//   busy_o, done_o, err_o   core stall, completion pulse, error pulse
//   wb_m_*                  Wishbone master port
module wb_master_bridge
  import wb_master_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    wr_i,
  input  logic [1:0]              size_i,
  input  logic                    unsigned_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   dat_from_core_i,
  output logic [DATA_WIDTH-1:0]   dat_to_core_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   wb_m_addr_o,
  input  logic [DATA_WIDTH-1:0]   wb_m_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_m_dat_o,
  output logic                    wb_m_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_m_sel_o,
  output logic                    wb_m_stb_o,
  output logic                    wb_m_cyc_o,
  input  logic                    wb_m_ack_i,
  input  logic                    wb_m_err_i
);

  localparam int SEL_W = wbd_sel(DATA_WIDTH);
  localparam int OFF_W = $clog2(SEL_W);
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [SEL_W-1:0]      r_sel;
  logic [DATA_WIDTH-1:0] r_wdat;
  logic [DATA_WIDTH-1:0] r_rdat;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [2:0]            r_addr_lo;
  logic                  r_err;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_idle;
  logic [1:0]            w_size;
  logic                  w_unsigned;
  logic [2:0]            w_addr_lo;
  logic [SEL_W-1:0]      w_sel;
  logic [DATA_WIDTH-1:0] w_bus_wdat;
  logic [DATA_WIDTH-1:0] w_core_rdat;
  logic                  w_misaligned;
  logic                  w_timeout;
  logic                  w_resp_err;

  // In IDLE the aligner works on the live request; once the cycle is
  // issued it works on the latched copy so read extension is stable.
  assign w_idle     = (r_state == IDLE);
  assign w_size     = w_idle ? size_i : r_size;
  assign w_unsigned = w_idle ? unsigned_i : r_unsigned;
  assign w_addr_lo  = w_idle ? addr_i[2:0] : r_addr_lo;

  wb_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .i_size       (w_size),
    .i_unsigned   (w_unsigned),
    .i_addr_lo    (w_addr_lo),
    .i_core_wdata (dat_from_core_i),
    .i_bus_rdata  (wb_m_dat_i),
    .o_sel        (w_sel),
    .o_bus_wdata  (w_bus_wdat),
    .o_core_rdata (w_core_rdat),
    .o_misaligned (w_misaligned)
  );

  // r_cnt counts BUS cycles already completed, so the abort edge is the one
  // closing the TIMEOUT_CYC-th cycle with STB high.
  assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_resp_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          w_resp_err  = w_misaligned;
          w_state_nxt = w_misaligned ? RESP : BUS;
        end
      end
      BUS: begin
        if (wb_m_err_i) begin
          w_resp_err  = 1'b1;
          w_state_nxt = RESP;
        end else if (wb_m_ack_i) begin
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_resp_err  = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_wdat     <= '0;
      r_rdat     <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr_lo  <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idle && req_i && !w_misaligned) begin
        r_addr     <= {addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        r_we       <= wr_i;
        r_sel      <= w_sel;
        r_wdat     <= w_bus_wdat;
        r_size     <= size_i;
        r_unsigned <= unsigned_i;
        r_addr_lo  <= addr_i[2:0];
        r_cnt      <= '0;
      end
      if (r_state == BUS && w_state_nxt == BUS && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // RESP is only ever entered from IDLE or BUS
      if (w_state_nxt == RESP) begin
        r_err <= w_resp_err;
        if (w_resp_err) begin
          r_rdat <= '0;
        end else if (!r_we) begin
          r_rdat <= w_core_rdat;
        end
      end
    end
  end

  // CYC/STB decode straight from the state register so reset kills them
  // without waiting for a clock edge.
  assign wb_m_cyc_o    = (r_state == BUS);
  assign wb_m_stb_o    = (r_state == BUS);
  assign wb_m_addr_o   = r_addr;
  assign wb_m_we_o     = r_we;
  assign wb_m_sel_o    = r_sel;
  assign wb_m_dat_o    = r_wdat;
  assign done_o        = (r_state == RESP);
  assign err_o         = (r_state == RESP) && r_err;
  assign busy_o        = !w_idle || req_i;
  assign dat_to_core_o = r_rdat;

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb/tb_wb_master_bridge.sv - directed self-checking bench for wb_master_bridge
module tb_wb_master_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        wr_i = 1'b0;
  logic [1:0]  size_i = 2'd0;
  logic        unsigned_i = 1'b0;
  logic [63:0] addr_i = '0;
  logic [63:0] dat_from_core_i = '0;
  logic [63:0] dat_to_core_o;
  logic        busy_o, done_o, err_o;
  logic [63:0] wb_m_addr_o;
  logic [63:0] wb_m_dat_i = '0;
  logic [63:0] wb_m_dat_o;
  logic        wb_m_we_o;
  logic [7:0]  wb_m_sel_o;
  logic        wb_m_stb_o, wb_m_cyc_o;
  logic        wb_m_ack_i = 1'b0;
  logic        wb_m_err_i = 1'b0;

  int errors = 0;
  int checks = 0;

  int          res_stb_n, res_lat;
  logic        res_done, res_err, res_done_after, res_busy_after, res_stb_after;
  logic [7:0]  res_sel;
  logic        res_we;
  logic [63:0] res_addr, res_dat;

  wb_master_bridge #(
    .ADDR_WIDTH  (64),
    .DATA_WIDTH  (64),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_i           (req_i),
    .wr_i            (wr_i),
    .size_i          (size_i),
    .unsigned_i      (unsigned_i),
    .addr_i          (addr_i),
    .dat_from_core_i (dat_from_core_i),
    .dat_to_core_o   (dat_to_core_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .wb_m_addr_o     (wb_m_addr_o),
    .wb_m_dat_i      (wb_m_dat_i),
    .wb_m_dat_o      (wb_m_dat_o),
    .wb_m_we_o       (wb_m_we_o),
    .wb_m_sel_o      (wb_m_sel_o),
    .wb_m_stb_o      (wb_m_stb_o),
    .wb_m_cyc_o      (wb_m_cyc_o),
    .wb_m_ack_i      (wb_m_ack_i),
    .wb_m_err_i      (wb_m_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdat);
    @(negedge clk_i);
    req_i = 1'b1;
    wr_i = wr;
    size_i = sz;
    unsigned_i = uns;
    addr_i = addr;
    dat_from_core_i = wdat;
  endtask

  // Acts as the slave: terminates in the (waits+1)-th STB cycle and records
  // what the bridge presented and when done_o arrived.
  task automatic do_bus(input int waits, input logic give_ack, input logic give_err,
                        input logic [63:0] rdata, input logic keep_req);
    res_stb_n = 0; res_lat = 0; res_done = 0; res_err = 0;
    res_done_after = 0; res_busy_after = 0; res_stb_after = 0;
    res_sel = '0; res_we = 0; res_addr = '0; res_dat = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_i);
      wb_m_ack_i = 1'b0;
      wb_m_err_i = 1'b0;
      if (wb_m_stb_o) begin
        res_stb_n++;
        if (res_stb_n == 1) begin
          res_sel = wb_m_sel_o; res_we = wb_m_we_o;
          res_addr = wb_m_addr_o; res_dat = wb_m_dat_o;
        end
        if (res_stb_n == waits + 1) begin
          wb_m_ack_i = give_ack;
          wb_m_err_i = give_err;
          wb_m_dat_i = rdata;
        end
      end
      if (done_o) begin
        res_done = 1'b1;
        res_err = err_o;
        res_lat = n;
        if (!keep_req) req_i = 1'b0;
        break;
      end
    end
    if (res_done) begin
      @(negedge clk_i);
      res_done_after = done_o;
      res_busy_after = busy_o;
      res_stb_after = wb_m_stb_o;
    end
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++; if (wb_m_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc got %b exp 0", wb_m_cyc_o); end
    checks++; if (wb_m_stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb got %b exp 0", wb_m_stb_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    checks++; if (dat_to_core_o !== 64'h0) begin errors++; $display("FAIL rst_rdat got %h exp 0", dat_to_core_o); end
    checks++; if (wb_m_sel_o !== 8'h00) begin errors++; $display("FAIL rst_sel got %h exp 00", wb_m_sel_o); end
    checks++; if (wb_m_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", wb_m_we_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_store_double;
    drive_req(1'b1, 2'd3, 1'b0, 64'h1000, 64'h1122334455667788);
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL sd_busy_req got %b exp 1", busy_o); end
    do_bus(2, 1'b1, 1'b0, 64'h0, 1'b0);
    checks++; if (res_done !== 1'b1) begin errors++; $display("FAIL sd_done got %b exp 1", res_done); end
    checks++; if (res_stb_n != 3) begin errors++; $display("FAIL sd_stb_cycles got %0d exp 3", res_stb_n); end
    checks++; if (res_lat != 4) begin errors++; $display("FAIL sd_latency got %0d exp 4", res_lat); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL sd_err got %b exp 0", res_err); end
    checks++; if (res_sel !== 8'hFF) begin errors++; $display("FAIL sd_sel got %h exp ff", res_sel); end
    checks++; if (res_we !== 1'b1) begin errors++; $display("FAIL sd_we got %b exp 1", res_we); end
    checks++; if (res_addr !== 64'h1000) begin errors++; $display("FAIL sd_addr got %h exp 1000", res_addr); end
    checks++; if (res_dat !== 64'h1122334455667788) begin errors++; $display("FAIL sd_wdat got %h exp 1122334455667788", res_dat); end
    checks++; if (res_done_after !== 1'b0) begin errors++; $display("FAIL sd_done_pulse got %b exp 0", res_done_after); end
    checks++; if (res_busy_after !== 1'b0) begin errors++; $display("FAIL sd_busy_after got %b exp 0", res_busy_after); end
  endtask

  task automatic test_load_byte;
    drive_req(1'b0, 2'd0, 1'b0, 64'h2005, 64'h0);
    do_bus(0, 1'b1, 1'b0, 64'h0000_8000_0000_0000, 1'b0);
    checks++; if (res_sel !== 8'h20) begin errors++; $display("FAIL lb_sel got %h exp 20", res_sel); end
    checks++; if (res_addr !== 64'h2000) begin errors++; $display("FAIL lb_addr got %h exp 2000", res_addr); end
    checks++; if (res_we !== 1'b0) begin errors++; $display("FAIL lb_we got %b exp 0", res_we); end
    checks++; if (res_lat != 2) begin errors++; $display("FAIL lb_latency got %0d exp 2", res_lat); end
    checks++; if (dat_to_core_o !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_signed got %h exp ffffffffffffff80", dat_to_core_o); end
    drive_req(1'b0, 2'd0, 1'b1, 64'h2005, 64'h0);
    do_bus(0, 1'b1, 1'b0, 64'h0000_8000_0000_0000, 1'b0);
    checks++; if (dat_to_core_o !== 64'h80) begin errors++; $display("FAIL lb_unsigned got %h exp 80", dat_to_core_o); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL lb_err got %b exp 0", res_err); end
  endtask

  task automatic test_load_word_store_byte;
    drive_req(1'b0, 2'd2, 1'b0, 64'h4004, 64'h0);
    do_bus(1, 1'b1, 1'b0, 64'h8765_4321_0000_0000, 1'b0);
    checks++; if (res_sel !== 8'hF0) begin errors++; $display("FAIL lw_sel got %h exp f0", res_sel); end
    checks++; if (dat_to_core_o !== 64'hFFFF_FFFF_8765_4321) begin errors++; $display("FAIL lw_data got %h exp ffffffff87654321", dat_to_core_o); end
    drive_req(1'b1, 2'd0, 1'b0, 64'h6003, 64'h0000_0000_0000_00AB);
    do_bus(0, 1'b1, 1'b0, 64'h0, 1'b0);
    checks++; if (res_sel !== 8'h08) begin errors++; $display("FAIL sb_sel got %h exp 08", res_sel); end
    checks++; if (res_dat !== 64'h0000_0000_AB00_0000) begin errors++; $display("FAIL sb_wdat got %h exp 00000000ab000000", res_dat); end
    checks++; if (dat_to_core_o !== 64'hFFFF_FFFF_8765_4321) begin errors++; $display("FAIL sb_rdat_hold got %h exp ffffffff87654321", dat_to_core_o); end
  endtask

  task automatic test_timeout;
    drive_req(1'b0, 2'd2, 1'b0, 64'h4004, 64'h0);
    do_bus(0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    checks++; if (res_stb_n != 4) begin errors++; $display("FAIL to_stb_cycles got %0d exp 4", res_stb_n); end
    checks++; if (res_lat != 5) begin errors++; $display("FAIL to_latency got %0d exp 5", res_lat); end
    checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", res_err); end
    checks++; if (dat_to_core_o !== 64'h0) begin errors++; $display("FAIL to_rdat got %h exp 0", dat_to_core_o); end
  endtask

  task automatic test_misaligned;
    drive_req(1'b0, 2'd1, 1'b1, 64'h5006, 64'h0);
    do_bus(0, 1'b1, 1'b0, 64'hBEEF_0000_0000_0000, 1'b0);
    checks++; if (res_sel !== 8'hC0) begin errors++; $display("FAIL lh_sel got %h exp c0", res_sel); end
    checks++; if (dat_to_core_o !== 64'hBEEF) begin errors++; $display("FAIL lh_data got %h exp beef", dat_to_core_o); end
    drive_req(1'b1, 2'd1, 1'b0, 64'h3003, 64'h1234);
    do_bus(0, 1'b1, 1'b0, 64'h0, 1'b0);
    checks++; if (res_stb_n != 0) begin errors++; $display("FAIL ma_stb_cycles got %0d exp 0", res_stb_n); end
    checks++; if (res_lat != 1) begin errors++; $display("FAIL ma_latency got %0d exp 1", res_lat); end
    checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL ma_err got %b exp 1", res_err); end
    checks++; if (dat_to_core_o !== 64'h0) begin errors++; $display("FAIL ma_rdat got %h exp 0", dat_to_core_o); end
    checks++; if (res_done_after !== 1'b0) begin errors++; $display("FAIL ma_done_pulse got %b exp 0", res_done_after); end
  endtask

  task automatic test_ack_err;
    drive_req(1'b1, 2'd2, 1'b0, 64'h7000, 64'hCAFE_BABE);
    do_bus(0, 1'b1, 1'b1, 64'h0, 1'b0);
    checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL ae_err got %b exp 1", res_err); end
    checks++; if (res_lat != 2) begin errors++; $display("FAIL ae_latency got %0d exp 2", res_lat); end
    drive_req(1'b0, 2'd3, 1'b0, 64'h7008, 64'h0);
    do_bus(0, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL ae_next_err got %b exp 0", res_err); end
    checks++; if (dat_to_core_o !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL ae_next_data got %h exp 0123456789abcdef", dat_to_core_o); end
  endtask

  task automatic test_back_to_back;
    drive_req(1'b0, 2'd0, 1'b1, 64'h9001, 64'h0);
    do_bus(0, 1'b1, 1'b0, 64'h0000_0000_0000_5500, 1'b1);
    checks++; if (dat_to_core_o !== 64'h55) begin errors++; $display("FAIL bb_first got %h exp 55", dat_to_core_o); end
    checks++; if (res_stb_after !== 1'b0) begin errors++; $display("FAIL bb_idle_gap_stb got %b exp 0", res_stb_after); end
    checks++; if (res_busy_after !== 1'b1) begin errors++; $display("FAIL bb_idle_gap_busy got %b exp 1", res_busy_after); end
    checks++; if (res_done_after !== 1'b0) begin errors++; $display("FAIL bb_done_pulse got %b exp 0", res_done_after); end
    addr_i = 64'h9002;
    do_bus(0, 1'b1, 1'b0, 64'h0000_0000_0066_0000, 1'b0);
    checks++; if (res_lat != 2) begin errors++; $display("FAIL bb_second_latency got %0d exp 2", res_lat); end
    checks++; if (res_sel !== 8'h04) begin errors++; $display("FAIL bb_second_sel got %h exp 04", res_sel); end
    checks++; if (dat_to_core_o !== 64'h66) begin errors++; $display("FAIL bb_second got %h exp 66", dat_to_core_o); end
  endtask

  task automatic test_reset_mid_cycle;
    drive_req(1'b0, 2'd3, 1'b0, 64'h8000, 64'h0);
    @(negedge clk_i);
    checks++; if (wb_m_stb_o !== 1'b1) begin errors++; $display("FAIL rm_stb_before got %b exp 1", wb_m_stb_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (wb_m_cyc_o !== 1'b0) begin errors++; $display("FAIL rm_cyc_async got %b exp 0", wb_m_cyc_o); end
    checks++; if (wb_m_stb_o !== 1'b0) begin errors++; $display("FAIL rm_stb_async got %b exp 0", wb_m_stb_o); end
    @(negedge clk_i);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rm_done_in_rst got %b exp 0", done_o); end
    rst_i = 1'b0;
    req_i = 1'b0;
    @(negedge clk_i);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rm_done_after got %b exp 0", done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rm_busy_after got %b exp 0", busy_o); end
    drive_req(1'b0, 2'd3, 1'b0, 64'h8008, 64'h0);
    do_bus(0, 1'b1, 1'b0, 64'hA5A5_0000_1234_5678, 1'b0);
    checks++; if (res_done !== 1'b1) begin errors++; $display("FAIL rm_post_done got %b exp 1", res_done); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL rm_post_err got %b exp 0", res_err); end
    checks++; if (dat_to_core_o !== 64'hA5A5_0000_1234_5678) begin errors++; $display("FAIL rm_post_data got %h exp a5a5000012345678", dat_to_core_o); end
  endtask

  initial begin
    test_reset();
    test_store_double();
    test_load_byte();
    test_load_word_store_byte();
    test_timeout();
    test_misaligned();
    test_ack_err();
    test_back_to_back();
    test_reset_mid_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
